// File: rtl/display_scan.sv
// display_scan: time-multiplexed digit scanner for the timer display.
// One shared 4-bit code output feeds the 7-segment decoder; one active-low
// select per position is driven for the second part of each slot, after a
// dead (guard) interval that suppresses ghosting between neighbouring digits.
// Display contents come from a shadow register that is only reloaded while
// idle or at a frame boundary, so a frame never shows a mix of old and new
// digits.
module display_scan #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] digits_in,
    input  logic        load,
    output logic        load_ack,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  blink_mask,
    output logic [3:0]  code_out,
    output logic [7:0]  sel_n,
    output logic        frame_done,
    output logic [1:0]  dbg_state_o
);

    // Load handshake: the requester raises load with digits_in and holds both
    // stable. The shadow register takes digits_in on an edge where load is
    // high and the scanner is idle or finishing the last slot of a frame;
    // load_ack is high for exactly the cycle after that edge. If load is still
    // high at a later boundary the value is taken and acknowledged again.

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = $clog2(BLINK_FRAMES) + 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [IW-1:0] idx_q;
    logic [31:0]   shadow_q;
    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;
    logic [3:0]    code_q;
    logic [7:0]    sel_n_q;
    logic          load_ack_q;
    logic          frame_done_q;

    logic          slot_end;
    logic          boundary;
    logic          load_take;
    logic          frame_pulse_d;
    logic [31:0]   shadow_d;
    logic [IW-1:0] idx_next;
    logic [2:0]    idx_sel;
    logic          digit_lit;
    logic [7:0]    sel_drive;
    logic [3:0]    code_first;
    logic [3:0]    code_next;

    // Code for position i of a 32-bit shadow word.
    function automatic logic [3:0] nibble(input logic [31:0] word, input logic [IW-1:0] pos);
        logic [4:0] base;
        base = 5'({pos, 2'b00});
        return word[base +: 4];
    endfunction

    // Slot/frame boundary detection, load acceptance and the select pattern
    // for the current digit (masks sampled every cycle).
    always_comb begin
        slot_end      = (state_q == ST_DRIVE) && (presc_q == PRESC_LAST);
        boundary      = slot_end && (idx_q == IDX_LAST);
        load_take     = load && ((state_q == ST_IDLE) || boundary);
        frame_pulse_d = enable && boundary;
        shadow_d      = load_take ? digits_in : shadow_q;
        idx_next      = boundary ? '0 : idx_q + 1'b1;
        idx_sel       = 3'(idx_q);
        digit_lit     = !blank_mask[idx_sel] && !(phase_q && blink_mask[idx_sel]);
        sel_drive     = digit_lit ? ~(8'd1 << idx_sel) : 8'hFF;
        code_first    = nibble(shadow_d, '0);
        code_next     = nibble(shadow_d, idx_next);
    end

    // Scan FSM with registered code/select/frame outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            idx_q        <= '0;
            code_q       <= 4'h0;
            sel_n_q      <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!enable) begin
                state_q <= ST_IDLE;
                presc_q <= '0;
                idx_q   <= '0;
                code_q  <= 4'h0;
                sel_n_q <= 8'hFF;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_GUARD;
                        presc_q <= '0;
                        idx_q   <= '0;
                        code_q  <= code_first;
                        sel_n_q <= 8'hFF;
                    end
                    ST_GUARD: begin
                        presc_q <= presc_q + 1'b1;
                        if (presc_q == GUARD_LAST) begin
                            state_q <= ST_DRIVE;
                            sel_n_q <= sel_drive;
                        end else begin
                            sel_n_q <= 8'hFF;
                        end
                    end
                    ST_DRIVE: begin
                        if (slot_end) begin
                            state_q      <= ST_GUARD;
                            presc_q      <= '0;
                            idx_q        <= idx_next;
                            code_q       <= code_next;
                            sel_n_q      <= 8'hFF;
                            frame_done_q <= boundary;
                        end else begin
                            presc_q <= presc_q + 1'b1;
                            sel_n_q <= sel_drive;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        presc_q <= '0;
                        idx_q   <= '0;
                        code_q  <= 4'h0;
                        sel_n_q <= 8'hFF;
                    end
                endcase
            end
        end
    end

    // Shadow register and its one-cycle acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= 32'h0;
            load_ack_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            load_ack_q <= load_take;
        end
    end

    // Blink frame counter; phase flips every BLINK_FRAMES completed frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (frame_pulse_d) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign code_out    = code_q;
    assign sel_n       = sel_n_q;
    assign load_ack    = load_ack_q;
    assign frame_done  = frame_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan with a small scan geometry (4 digits, 4-cycle slots,
// 1 guard cycle, 2-frame blink). The reference model tracks absolute time
// since scan start and derives digit, slot position and frame from it.
module tb_display_scan;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int GUARD        = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;
    localparam int W            = 14;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] digits_in;
    logic        load;
    logic        load_ack;
    logic [7:0]  blank_mask;
    logic [7:0]  blink_mask;
    logic [3:0]  code_out;
    logic [7:0]  sel_n;
    logic        frame_done;
    logic [1:0]  dbg_state;

    display_scan #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .GUARD(GUARD),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .digits_in(digits_in),
        .load(load),
        .load_ack(load_ack),
        .blank_mask(blank_mask),
        .blink_mask(blink_mask),
        .code_out(code_out),
        .sel_n(sel_n),
        .frame_done(frame_done),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    // reference model state
    int          m_t;
    logic [31:0] m_shadow;
    int          m_bcnt;
    logic        m_phase;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_nib(input logic [31:0] w, input int d);
        logic [31:0] sh;
        sh = w >> (4 * d);
        return sh[3:0];
    endfunction

    function automatic bit model_in_drive(input int d);
        return (m_t >= 0) && (((m_t / SCAN_DIV) % DIGITS) == d) && ((m_t % SCAN_DIV) >= GUARD);
    endfunction

    task automatic model_reset();
        m_t      = -1;
        m_shadow = 32'h0;
        m_bcnt   = 0;
        m_phase  = 1'b0;
        exp_q.delete();
    endtask

    // One clock: predict outputs after the edge from the current inputs,
    // push the prediction, clock, then pop and compare.
    task automatic step(output bit took);
        logic [W-1:0] e;
        bit           idle;
        bit           bnd;
        bit           fd;
        int           pos;
        int           dig;
        logic [7:0]   s;
        logic [3:0]   c;
        idle = (m_t < 0);
        bnd  = !idle && ((m_t % FRAME) == FRAME - 1);
        took = load && (idle || bnd);
        if (took) m_shadow = digits_in;
        fd = 1'b0;
        s  = 8'hFF;
        c  = 4'h0;
        if (!enable) begin
            m_t = -1;
        end else begin
            m_t = idle ? 0 : m_t + 1;
            pos = m_t % SCAN_DIV;
            dig = (m_t / SCAN_DIV) % DIGITS;
            if (m_t > 0 && (m_t % FRAME) == 0) begin
                fd = 1'b1;
                m_bcnt++;
                if (m_bcnt == BLINK_FRAMES) begin
                    m_bcnt  = 0;
                    m_phase = ~m_phase;
                end
            end
            c = model_nib(m_shadow, dig);
            if (pos >= GUARD && !blank_mask[dig] && !(m_phase && blink_mask[dig])) s[dig] = 1'b0;
        end
        exp_q.push_back({s, c, fd, took});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("sel_n", sel_n, e[13:6]);
        check_eq("code_out", code_out, e[5:2]);
        check_eq("frame_done", frame_done, e[1]);
        check_eq("load_ack", load_ack, e[0]);
    endtask

    task automatic run(input int n);
        bit t;
        for (int i = 0; i < n; i++) step(t);
    endtask

    task automatic run_until_drive(input int d, input string tag);
        bit t;
        bit hit;
        hit = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (model_in_drive(d)) begin
                hit = 1;
                break;
            end
            step(t);
        end
        check_eq(tag, hit, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sel_n"}, sel_n, 8'hFF);
        check_eq({tag, "_code"}, code_out, 4'h0);
        check_eq({tag, "_ack"}, load_ack, 1'b0);
        check_eq({tag, "_fd"}, frame_done, 1'b0);
        check_eq({tag, "_state"}, dbg_state, 2'd0);
    endtask

    // stimulus
    initial begin
        bit took;
        bit seen;
        rst_n      = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        digits_in  = 32'h0;
        blank_mask = 8'h00;
        blink_mask = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        run(3);

        // load while idle: ack one cycle later
        load      = 1'b1;
        digits_in = 32'h0000_4321;
        step(took);
        load      = 1'b0;
        digits_in = 32'hDEAD_BEEF;
        run(2);

        // basic scan, three frames
        enable = 1'b1;
        run(3 * FRAME);

        // mid-frame load during digit 1 drive: latched at the boundary
        run_until_drive(1, "reach_d1_drive");
        load      = 1'b1;
        digits_in = 32'h0000_9876;
        seen      = 0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            step(took);
            if (load_ack) seen = 1;
        end
        load = 1'b0;
        check_eq("load_ack_wait", seen, 1'b1);
        run(FRAME + 2);

        // blank digit 1, blink digit 0
        blank_mask = 8'h02;
        blink_mask = 8'h01;
        run(8 * FRAME);
        blank_mask = 8'h00;
        blink_mask = 8'h00;

        // enable dropped during digit 2, then resumed
        run_until_drive(2, "reach_d2_drive");
        enable = 1'b0;
        run(5);
        enable = 1'b1;
        run(2 * FRAME);

        // enable falls on a frame boundary with load high
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_t >= 0 && (m_t % FRAME) == FRAME - 1) break;
            step(took);
        end
        load      = 1'b1;
        digits_in = 32'h0000_FA0B;
        enable    = 1'b0;
        step(took);
        check_eq("boundary_disable_take", took, 1'b1);
        load = 1'b0;
        run(2);

        // codes A and F pass through unchanged
        enable = 1'b1;
        run(2 * FRAME);

        // randomised masks, loads and occasional enable drops
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) blank_mask = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) blink_mask = 8'($urandom_range(0, 255));
            if (!load && $urandom_range(0, 20) == 0) begin
                load      = 1'b1;
                digits_in = $urandom;
            end
            if ($urandom_range(0, 60) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 4) == 0) enable = 1'b1;
            step(took);
            if (took) load = 1'b0;
        end

        // asynchronous reset in the middle of a drive interval
        enable     = 1'b1;
        load       = 1'b0;
        blank_mask = 8'h00;
        blink_mask = 8'h00;
        run_until_drive(1, "reach_rst_drive");
        check_eq("pre_rst_sel_low", sel_n, 8'hFD);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        enable = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        rst_n = 1'b1;
        run(4);
        enable = 1'b1;
        run(FRAME + 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
